// File: rtl/me_result_rx_pkg.sv
// ---------------------------------------------------------------------------
// me_result_rx_pkg
// Shared motion-estimation definitions used by both the result serializer
// and the result deserializer (me_result_rx).
//   ME_SAD_W / ME_MV_W : default SAD and motion-vector component widths
//   ME_IDX_W           : macroblock index width carried with every word
//   me_res_word_t      : result word layout {sad, mvx, mvy, idx}, MSB first
//   res_word_w()       : packed word width for a given SAD/MV width
//   rx_state_e         : deserializer FSM states
// ---------------------------------------------------------------------------
package me_result_rx_pkg;

  localparam int ME_SAD_W = 14;
  localparam int ME_MV_W  = 4;
  localparam int ME_IDX_W = 16;

  // Word layout at the default widths; fields are packed MSB first in this
  // order wherever a result word is stored or transported.
  typedef struct packed {
    logic [ME_SAD_W-1:0] sad;
    logic [ME_MV_W-1:0]  mvx;
    logic [ME_MV_W-1:0]  mvy;
    logic [ME_IDX_W-1:0] idx;
  } me_res_word_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } rx_state_e;

  function automatic int res_word_w(input int sad_w, input int mv_w);
    return sad_w + 2 * mv_w + ME_IDX_W;
  endfunction

endpackage

// File: rtl/me_res_fifo.sv
// ---------------------------------------------------------------------------
// me_res_fifo
// Result-word FIFO between the deserializer and the downstream consumer.
// A push into a full FIFO is refused unless a pop happens on the same edge.
//   clk, rst_n  : clock, asynchronous active-low reset
//   push_i      : offer wdata_i for storage this edge
//   wdata_i     : word to store
//   pop_i       : consumer takes the head word (ignored when empty)
//   rdata_o     : head word, forced to zero while empty
//   valid_o     : head word available
//   full_o      : no free entry
//   accept_o    : push_i is being accepted this edge
// ---------------------------------------------------------------------------
module me_res_fifo #(
  parameter int WIDTH = 38,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             valid_o,
  output logic             full_o,
  output logic             accept_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign valid_o  = (count_q != '0);
  assign full_o   = (count_q == FULL_CNT);
  assign do_pop   = pop_i && valid_o;
  // A full FIFO still takes a word when the head leaves on the same edge.
  assign do_push  = push_i && (!full_o || do_pop);
  assign accept_o = do_push;
  // Gated so the data outputs read zero after reset and whenever empty.
  assign rdata_o  = valid_o ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/me_result_rx.sv
// ---------------------------------------------------------------------------
// me_result_rx
// Deserializes motion-estimation results (SAD plus MV x/y, all MSB first)
// into words tagged with a running macroblock index and queues them in
// me_res_fifo for a ready/valid consumer.
//   clk, rst_n          : clock, asynchronous active-low reset
//   sign_in             : one-cycle start strobe with the MSB of each word
//   sad_in, x_in, y_in  : serial SAD / MV x / MV y bits
//   res_ready           : consumer accepts the head word
//   err_clr             : clears overflow and frame_err
//   res_valid           : head word available
//   res_sad/mvx/mvy/idx : fields of the head word
//   busy                : a word is being shifted in
//   overflow            : sticky, a completed word was dropped (FIFO full)
//   frame_err           : sticky, sign_in arrived inside an incomplete word
// ---------------------------------------------------------------------------
module me_result_rx
  import me_result_rx_pkg::*;
#(
  parameter int SAD_W = ME_SAD_W,
  parameter int MV_W  = ME_MV_W,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sign_in,
  input  logic                sad_in,
  input  logic                x_in,
  input  logic                y_in,
  input  logic                res_ready,
  input  logic                err_clr,
  output logic                res_valid,
  output logic [SAD_W-1:0]    res_sad,
  output logic [MV_W-1:0]     res_mvx,
  output logic [MV_W-1:0]     res_mvy,
  output logic [ME_IDX_W-1:0] res_idx,
  output logic                busy,
  output logic                overflow,
  output logic                frame_err
);

  localparam int WORD_W = res_word_w(SAD_W, MV_W);
  localparam int CNT_W  = $clog2(SAD_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAD_W - 1);
  localparam logic [CNT_W-1:0] CNT_MV   = CNT_W'(MV_W);

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SAD_W-1:0]     sad_q, sad_d;
  logic [MV_W-1:0]      mvx_q, mvx_d;
  logic [MV_W-1:0]      mvy_q, mvy_d;
  logic [ME_IDX_W-1:0]  idx_q, idx_d;
  logic                 ovf_q, ovf_d;
  logic                 ferr_q, ferr_d;
  logic                 push, frame_set, pop, accept, fifo_full;
  logic [WORD_W-1:0]    push_word, head_word;

  // Shift registers fill from the LSB; after a full word the first bit
  // received sits in the MSB, so no explicit clearing is needed at start.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sad_d     = sad_q;
    mvx_d     = mvx_q;
    mvy_d     = mvy_q;
    push      = 1'b0;
    frame_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sign_in) begin
          sad_d   = SAD_W'({sad_q, sad_in});
          mvx_d   = MV_W'({mvx_q, x_in});
          mvy_d   = MV_W'({mvy_q, y_in});
          cnt_d   = CNT_W'(1);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sad_d = SAD_W'({sad_q, sad_in});
        if (sign_in) begin
          // Restart: the partial word is abandoned, current bits are MSBs.
          mvx_d     = MV_W'({mvx_q, x_in});
          mvy_d     = MV_W'({mvy_q, y_in});
          cnt_d     = CNT_W'(1);
          frame_set = 1'b1;
        end else begin
          if (cnt_q < CNT_MV) begin
            mvx_d = MV_W'({mvx_q, x_in});
            mvy_d = MV_W'({mvy_q, y_in});
          end
          if (cnt_q == CNT_LAST) begin
            push    = 1'b1;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The word is pushed on the edge that captures its last bit, so the
  // just-shifted values are used rather than the registered ones.
  assign push_word = {sad_d, mvx_d, mvy_d, idx_q};
  assign pop       = res_valid && res_ready;

  always_comb begin
    idx_d  = accept ? idx_q + 1'b1 : idx_q;
    // A set event on the same edge wins over err_clr.
    ovf_d  = (push && !accept) ? 1'b1 : (err_clr ? 1'b0 : ovf_q);
    ferr_d = frame_set ? 1'b1 : (err_clr ? 1'b0 : ferr_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
      ferr_q  <= ferr_d;
    end
  end

  always_ff @(posedge clk) begin
    sad_q <= sad_d;
    mvx_q <= mvx_d;
    mvy_q <= mvy_d;
  end

  me_res_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_i   (push),
    .wdata_i  (push_word),
    .pop_i    (pop),
    .rdata_o  (head_word),
    .valid_o  (res_valid),
    .full_o   (fifo_full),
    .accept_o (accept)
  );

  assign {res_sad, res_mvx, res_mvy, res_idx} = head_word;
  assign busy      = (state_q == ST_SHIFT);
  assign overflow  = ovf_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_me_result_rx.sv
module tb_me_result_rx;

  localparam int SAD_W = 14;
  localparam int MV_W  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sign_in = 1'b0, sad_in = 1'b0, x_in = 1'b0, y_in = 1'b0;
  logic        res_ready = 1'b0, err_clr = 1'b0;
  logic        res_valid;
  logic [13:0] res_sad;
  logic [3:0]  res_mvx, res_mvy;
  logic [15:0] res_idx;
  logic        busy, overflow, frame_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  me_result_rx #(.SAD_W(SAD_W), .MV_W(MV_W), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .sign_in(sign_in), .sad_in(sad_in),
    .x_in(x_in), .y_in(y_in), .res_ready(res_ready), .err_clr(err_clr),
    .res_valid(res_valid), .res_sad(res_sad), .res_mvx(res_mvx),
    .res_mvy(res_mvy), .res_idx(res_idx), .busy(busy),
    .overflow(overflow), .frame_err(frame_err)
  );

  typedef struct {
    logic [13:0] sad;
    logic [3:0]  x;
    logic [3:0]  y;
    logic [13:0] e_sad;
    logic [3:0]  e_x;
    logic [3:0]  e_y;
    logic [15:0] e_idx;
  } vec_t;

  vec_t        tbl [4];
  logic [13:0] ovw [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic [13:0] s, input logic [3:0] x,
                            input logic [3:0] y, input logic [15:0] idx);
    chk({tag, "_valid"}, {31'd0, res_valid}, 32'd1);
    chk({tag, "_sad"}, {18'd0, res_sad}, {18'd0, s});
    chk({tag, "_mvx"}, {28'd0, res_mvx}, {28'd0, x});
    chk({tag, "_mvy"}, {28'd0, res_mvy}, {28'd0, y});
    chk({tag, "_idx"}, {16'd0, res_idx}, {16'd0, idx});
  endtask

  // Drives the first nbits of a word, one bit per cycle from the negedge.
  // Bits past the MV window are driven to 1 so stray MV shifts show up.
  task automatic drive_word(input logic [13:0] s, input logic [3:0] x, input logic [3:0] y,
                            input int nbits, input bit clr_first);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      sign_in = (i == 0);
      sad_in  = s[SAD_W-1-i];
      x_in    = (i < MV_W) ? x[MV_W-1-i] : 1'b1;
      y_in    = (i < MV_W) ? y[MV_W-1-i] : 1'b1;
      err_clr = clr_first && (i == 0);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    sign_in = 1'b0; sad_in = 1'b0; x_in = 1'b0; y_in = 1'b0; err_clr = 1'b0;
  endtask

  task automatic pop_one();
    @(negedge clk);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; res_ready = 1'b0; err_clr = 1'b0;
    sign_in = 1'b0; sad_in = 1'b0; x_in = 1'b0; y_in = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{14'h2A5C, 4'h9, 4'h3, 14'h2A5C, 4'h9, 4'h3, 16'd0};
    tbl[1] = '{14'h3FFF, 4'hF, 4'hF, 14'h3FFF, 4'hF, 4'hF, 16'd1};
    tbl[2] = '{14'h0000, 4'h0, 4'h0, 14'h0000, 4'h0, 4'h0, 16'd2};
    tbl[3] = '{14'h1555, 4'hA, 4'h5, 14'h1555, 4'hA, 4'h5, 16'd3};
    ovw[0] = 14'h0AAA; ovw[1] = 14'h1BBB; ovw[2] = 14'h2CCC;
    ovw[3] = 14'h3DDD; ovw[4] = 14'h0EEE; ovw[5] = 14'h1FFF;

    // Reset state
    #1;
    chk("rst_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_sad", {18'd0, res_sad}, 32'd0);
    chk("rst_idx", {16'd0, res_idx}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_ferr", {31'd0, frame_err}, 32'd0);
    do_reset();

    // Single words with res_ready=1: valid appears 14 cycles after sign_in
    res_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      drive_word(tbl[v].sad, tbl[v].x, tbl[v].y, SAD_W, 1'b0);
      chk("tbl_prevalid", {31'd0, res_valid}, 32'd0);
      chk("tbl_busy", {31'd0, busy}, 32'd1);
      idle();
      check_head("tbl", tbl[v].e_sad, tbl[v].e_x, tbl[v].e_y, tbl[v].e_idx);
      chk("tbl_busy_done", {31'd0, busy}, 32'd0);
      idle();
      chk("tbl_popped", {31'd0, res_valid}, 32'd0);
    end

    // Three back-to-back words held in the FIFO
    do_reset();
    drive_word(14'h0123, 4'h1, 4'h2, SAD_W, 1'b0);
    drive_word(14'h3ABC, 4'hC, 4'h7, SAD_W, 1'b0);
    drive_word(14'h2001, 4'h8, 4'hE, SAD_W, 1'b0);
    idle();
    check_head("b2b_w0", 14'h0123, 4'h1, 4'h2, 16'd0);
    repeat (3) idle();
    check_head("b2b_hold", 14'h0123, 4'h1, 4'h2, 16'd0);
    chk("b2b_ovf", {31'd0, overflow}, 32'd0);
    pop_one();
    check_head("b2b_w1", 14'h3ABC, 4'hC, 4'h7, 16'd1);
    pop_one();
    check_head("b2b_w2", 14'h2001, 4'h8, 4'hE, 16'd2);
    pop_one();
    chk("b2b_empty", {31'd0, res_valid}, 32'd0);

    // Six words into a depth-4 FIFO: last two dropped
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive_word(ovw[k], 4'(k + 1), 4'(k + 8), SAD_W, 1'b0);
      idle();
      chk("ovf_flag", {31'd0, overflow}, (k >= 4) ? 32'd1 : 32'd0);
    end
    for (int k = 0; k < 4; k++) begin
      check_head("ovf_keep", ovw[k], 4'(k + 1), 4'(k + 8), 16'(k));
      pop_one();
    end
    chk("ovf_empty", {31'd0, res_valid}, 32'd0);
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);
    @(negedge clk); err_clr = 1'b1;
    idle();
    chk("ovf_clr", {31'd0, overflow}, 32'd0);

    // Push and pop on the same edge while full
    do_reset();
    for (int k = 0; k < 4; k++) drive_word(ovw[k], 4'(k + 1), 4'(k + 8), SAD_W, 1'b0);
    drive_word(ovw[4], 4'h5, 4'hC, SAD_W, 1'b0);
    res_ready = 1'b1;
    idle();
    res_ready = 1'b0;
    chk("fullpp_ovf", {31'd0, overflow}, 32'd0);
    check_head("fullpp_h1", ovw[1], 4'h2, 4'h9, 16'd1);
    pop_one(); pop_one(); pop_one();
    check_head("fullpp_h4", ovw[4], 4'h5, 4'hC, 16'd4);

    // sign_in at bit 7 restarts the word
    do_reset();
    res_ready = 1'b1;
    drive_word(14'h3C3C, 4'h5, 4'hA, 7, 1'b0);
    drive_word(14'h1234, 4'h6, 4'hB, SAD_W, 1'b0);
    idle();
    check_head("frm_b", 14'h1234, 4'h6, 4'hB, 16'd0);
    chk("frm_err", {31'd0, frame_err}, 32'd1);
    idle();
    chk("frm_nopartial", {31'd0, res_valid}, 32'd0);
    @(negedge clk); err_clr = 1'b1;
    idle();
    chk("frm_clr", {31'd0, frame_err}, 32'd0);
    drive_word(14'h2222, 4'h1, 4'h1, 3, 1'b0);
    drive_word(14'h0F0F, 4'h3, 4'hC, SAD_W, 1'b1);
    idle();
    check_head("frm_d", 14'h0F0F, 4'h3, 4'hC, 16'd1);
    chk("frm_set_over_clr", {31'd0, frame_err}, 32'd1);

    // Reset asserted mid-word
    do_reset();
    drive_word(14'h2A5C, 4'h9, 4'h3, SAD_W, 1'b0);
    idle();
    chk("mrst_held", {31'd0, res_valid}, 32'd1);
    drive_word(14'h3FFF, 4'hF, 4'hF, 5, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_valid", {31'd0, res_valid}, 32'd0);
    chk("mrst_sad", {18'd0, res_sad}, 32'd0);
    chk("mrst_mvx", {28'd0, res_mvx}, 32'd0);
    chk("mrst_mvy", {28'd0, res_mvy}, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    idle();
    rst_n = 1'b1;
    idle();
    chk("mrst_empty", {31'd0, res_valid}, 32'd0);
    res_ready = 1'b1;
    drive_word(14'h1A2B, 4'h7, 4'h4, SAD_W, 1'b0);
    idle();
    check_head("mrst_next", 14'h1A2B, 4'h7, 4'h4, 16'd0);

    // Index wrap: index preset to 16'hFFFF instead of 65535 real words
    do_reset();
    res_ready = 1'b1;
    @(negedge clk);
    force dut.idx_q = 16'hFFFF;
    #1 release dut.idx_q;
    drive_word(14'h0101, 4'h2, 4'h4, SAD_W, 1'b0);
    idle();
    check_head("wrap_last", 14'h0101, 4'h2, 4'h4, 16'hFFFF);
    drive_word(14'h0202, 4'h4, 4'h8, SAD_W, 1'b0);
    idle();
    check_head("wrap_zero", 14'h0202, 4'h4, 4'h8, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
